// File: rtl/sd_spi_cmd_sequencer_pkg.sv
// Shared types, constants and CRC7 helpers for the SD-card SPI command path.
package sd_spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    POLL,
    TAIL,
    DONE
  } seq_state_t;

  localparam logic [1:0] CMD_START = 2'b01;
  localparam logic [7:0] FILL_BYTE = 8'hFF;
  localparam logic [6:0] CRC7_POLY = 7'h09;

  // One MSB-first step of the x^7+x^3+1 CRC.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = crc[6] ^ din;
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

  // CRC7 over the first 40 bits of a command frame, MSB first, init 0.
  function automatic logic [6:0] crc7_calc(input logic [39:0] bits);
    logic [6:0] crc;
    crc = 7'h00;
    for (int i = 39; i >= 0; i--) begin
      crc = crc7_step(crc, bits[i]);
    end
    return crc;
  endfunction

endpackage

// File: rtl/sd_spi_cmd_sequencer_byte_xfer.sv
// SPI mode-0 byte engine: sclk divider plus 8-bit full-duplex shifter.
// o_done flags the final clock of a byte; a start seen in that clock chains
// the next byte with no idle gap on sclk.
module sd_spi_byte_xfer #(
  parameter int DIV_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [7:0]       i_tx_byte,
  input  logic [DIV_W-1:0] i_div,
  input  logic             i_miso,
  output logic             o_sclk,
  output logic             o_mosi,
  output logic             o_done,
  output logic [7:0]       o_rx_byte
);

  logic             r_active;
  logic             r_sclk;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_phase_cnt;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_tx;
  logic [7:0]       r_rx;

  logic w_phase_end;
  logic w_last;

  assign w_phase_end = r_active && (r_phase_cnt == r_div);
  assign w_last      = w_phase_end && r_sclk && (r_bit_cnt == 3'd7);

  assign o_done    = w_last;
  assign o_sclk    = r_sclk;
  assign o_mosi    = r_active ? r_tx[7] : 1'b1;
  assign o_rx_byte = r_rx;

  // Phase timing, sclk toggling, MOSI shift on fall and MISO capture on rise.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_active    <= 1'b0;
      r_sclk      <= 1'b0;
      r_div       <= '0;
      r_phase_cnt <= '0;
      r_bit_cnt   <= '0;
      r_tx        <= 8'hFF;
      r_rx        <= 8'hFF;
    end else if (i_start && (!r_active || w_last)) begin
      r_active    <= 1'b1;
      r_sclk      <= 1'b0;
      r_div       <= i_div;
      r_phase_cnt <= '0;
      r_bit_cnt   <= '0;
      r_tx        <= i_tx_byte;
    end else if (w_phase_end) begin
      r_phase_cnt <= '0;
      if (!r_sclk) begin
        r_sclk <= 1'b1;
        r_rx   <= {r_rx[6:0], i_miso};
      end else begin
        r_sclk <= 1'b0;
        if (w_last) begin
          r_active <= 1'b0;
        end else begin
          r_bit_cnt <= r_bit_cnt + 3'd1;
          r_tx      <= {r_tx[6:0], 1'b1};
        end
      end
    end else if (r_active) begin
      r_phase_cnt <= r_phase_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/sd_spi_cmd_sequencer.sv
// SD SPI-mode command sequencer: frames a command with CRC7, sends it,
// polls for R1 with a bounded byte count, sends one trailing fill byte.
module sd_spi_cmd_sequencer
  import sd_spi_pkg::*;
#(
  parameter int DIV_W   = 8,
  parameter int NCR_MAX = 8
) (
  input  logic             sd_clock_i,
  input  logic             sd_reset_i,
  input  logic [DIV_W-1:0] clk_div,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [5:0]       cmd_index,
  input  logic [31:0]      cmd_arg,
  output logic             resp_valid,
  output logic [7:0]       resp_r1,
  output logic             resp_timeout,
  output logic             busy,
  output logic             spi_sclk,
  output logic             spi_mosi,
  input  logic             spi_miso,
  output logic             spi_cs_n
);

  localparam logic [7:0] NCR_LAST = 8'(NCR_MAX - 1);

  seq_state_t       r_state;
  logic [5:0]       r_index;
  logic [31:0]      r_arg;
  logic [DIV_W-1:0] r_div;
  logic [2:0]       r_byte_cnt;
  logic [7:0]       r_poll_cnt;
  logic [7:0]       r_r1_pend;
  logic             r_to_pend;
  logic [7:0]       r_r1;
  logic             r_timeout;
  logic             r_cs_n;

  seq_state_t       w_next_state;
  logic             w_start;
  logic [7:0]       w_tx_byte;
  logic [DIV_W-1:0] w_div;
  logic [7:0]       w_frame_next;
  logic [6:0]       w_crc;
  logic             w_x_done;
  logic [7:0]       w_rx_byte;

  assign w_crc        = crc7_calc({CMD_START, r_index, r_arg});
  assign cmd_ready    = (r_state == IDLE);
  assign busy         = (r_state != IDLE);
  assign resp_valid   = (r_state == DONE);
  assign resp_r1      = r_r1;
  assign resp_timeout = r_timeout;
  assign spi_cs_n     = r_cs_n;

  sd_spi_byte_xfer #(.DIV_W(DIV_W)) u_xfer (
    .i_clk     (sd_clock_i),
    .i_rst     (sd_reset_i),
    .i_start   (w_start),
    .i_tx_byte (w_tx_byte),
    .i_div     (w_div),
    .i_miso    (spi_miso),
    .o_sclk    (spi_sclk),
    .o_mosi    (spi_mosi),
    .o_done    (w_x_done),
    .o_rx_byte (w_rx_byte)
  );

  // Byte that follows the one currently on the wire during SEND.
  always_comb begin
    w_frame_next = FILL_BYTE;
    case (r_byte_cnt)
      3'd0:    w_frame_next = r_arg[31:24];
      3'd1:    w_frame_next = r_arg[23:16];
      3'd2:    w_frame_next = r_arg[15:8];
      3'd3:    w_frame_next = r_arg[7:0];
      default: w_frame_next = {w_crc, 1'b1};
    endcase
  end

  // Next state and byte-engine start/data; the first byte leaves on accept.
  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_tx_byte    = FILL_BYTE;
    w_div        = r_div;
    case (r_state)
      IDLE: begin
        w_div = clk_div;
        if (cmd_valid) begin
          w_start      = 1'b1;
          w_tx_byte    = {CMD_START, cmd_index};
          w_next_state = SEND;
        end
      end
      SEND: begin
        if (w_x_done) begin
          w_start = 1'b1;
          if (r_byte_cnt == 3'd5) begin
            w_next_state = POLL;
          end else begin
            w_tx_byte = w_frame_next;
          end
        end
      end
      POLL: begin
        if (w_x_done) begin
          w_start = 1'b1;
          if (!w_rx_byte[7] || (r_poll_cnt == NCR_LAST)) begin
            w_next_state = TAIL;
          end
        end
      end
      TAIL: begin
        if (w_x_done) begin
          w_next_state = DONE;
        end
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // State register, command latches, counters and response holding registers.
  always_ff @(posedge sd_clock_i or posedge sd_reset_i) begin
    if (sd_reset_i) begin
      r_state    <= IDLE;
      r_index    <= '0;
      r_arg      <= '0;
      r_div      <= '0;
      r_byte_cnt <= '0;
      r_poll_cnt <= '0;
      r_r1_pend  <= FILL_BYTE;
      r_to_pend  <= 1'b0;
      r_r1       <= FILL_BYTE;
      r_timeout  <= 1'b0;
      r_cs_n     <= 1'b1;
    end else begin
      r_state <= w_next_state;
      r_cs_n  <= (w_next_state == IDLE) || (w_next_state == DONE);
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            r_index    <= cmd_index;
            r_arg      <= cmd_arg;
            r_div      <= clk_div;
            r_byte_cnt <= '0;
            r_poll_cnt <= '0;
            r_r1_pend  <= FILL_BYTE;
            r_to_pend  <= 1'b0;
            r_timeout  <= 1'b0;
          end
        end
        SEND: begin
          if (w_x_done && (r_byte_cnt != 3'd5)) begin
            r_byte_cnt <= r_byte_cnt + 3'd1;
          end
        end
        POLL: begin
          if (w_x_done) begin
            if (!w_rx_byte[7]) begin
              r_r1_pend <= w_rx_byte;
            end else if (r_poll_cnt == NCR_LAST) begin
              r_r1_pend <= FILL_BYTE;
              r_to_pend <= 1'b1;
            end
            if (r_poll_cnt != 8'hFF) begin
              r_poll_cnt <= r_poll_cnt + 8'd1;
            end
          end
        end
        TAIL: begin
          if (w_x_done) begin
            r_r1      <= r_r1_pend;
            r_timeout <= r_to_pend;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_spi_cmd_sequencer.sv
// Scoreboard bench for the SD SPI command sequencer with a simple card model.
module tb_sd_spi_cmd_sequencer;

  typedef struct {
    logic [7:0] r1;
    logic       timeout;
  } respExp_t;

  typedef struct {
    int csLen;
    int firstRise;
  } txnExp_t;

  logic        sd_clock_i = 1'b0;
  logic        sd_reset_i = 1'b1;
  logic [7:0]  clk_div    = 8'd0;
  logic        cmd_valid  = 1'b0;
  logic        cmd_ready;
  logic [5:0]  cmd_index  = 6'd0;
  logic [31:0] cmd_arg    = 32'd0;
  logic        resp_valid;
  logic [7:0]  resp_r1;
  logic        resp_timeout;
  logic        busy;
  logic        spi_sclk;
  logic        spi_mosi;
  logic        spi_miso   = 1'b1;
  logic        spi_cs_n;

  logic [7:0] expBytes[$];
  respExp_t   expResp[$];
  txnExp_t    expTxn[$];

  int nChecks = 0;
  int nErrors = 0;

  int         cardRespAt  = 0;
  logic [7:0] cardRespVal = 8'hFF;
  logic [7:0] lastR1      = 8'hFF;
  logic       lastTo      = 1'b0;

  sd_spi_cmd_sequencer #(.DIV_W(8), .NCR_MAX(8)) dut (
    .sd_clock_i   (sd_clock_i),
    .sd_reset_i   (sd_reset_i),
    .clk_div      (clk_div),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_index    (cmd_index),
    .cmd_arg      (cmd_arg),
    .resp_valid   (resp_valid),
    .resp_r1      (resp_r1),
    .resp_timeout (resp_timeout),
    .busy         (busy),
    .spi_sclk     (spi_sclk),
    .spi_mosi     (spi_mosi),
    .spi_miso     (spi_miso),
    .spi_cs_n     (spi_cs_n)
  );

  // 100 MHz-style system clock
  always #5 sd_clock_i = ~sd_clock_i;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Card model: returns 0xFF except for the chosen poll byte; MISO moves after sclk falls
  int         cardBit  = 0;
  int         cardByte = 0;
  logic [7:0] cardTx   = 8'hFF;
  logic       cardPrev = 1'b0;
  always @(negedge sd_clock_i) begin
    if (spi_cs_n || sd_reset_i) begin
      cardBit  = 0;
      cardByte = 0;
      cardTx   = 8'hFF;
    end else if (cardPrev && !spi_sclk) begin
      cardBit++;
      if (cardBit == 8) begin
        cardBit = 0;
        cardByte++;
        cardTx = (cardRespAt > 0 && (cardByte - 5) == cardRespAt) ? cardRespVal : 8'hFF;
      end
    end
    spi_miso = cardTx[3'(7 - cardBit)];
    cardPrev = spi_sclk;
  end

  // SPI monitor: rebuilds MOSI bytes on sclk rises and times each chip-select window
  int         csCnt     = 0;
  int         firstRise = 0;
  int         monBits   = 0;
  logic       sawRise   = 1'b0;
  logic       monPrev   = 1'b0;
  logic [7:0] monShift  = 8'h00;
  txnExp_t    monTxn;
  always @(negedge sd_clock_i) begin
    if (sd_reset_i) begin
      csCnt   = 0;
      monBits = 0;
      sawRise = 1'b0;
    end else if (!spi_cs_n) begin
      if (!monPrev && spi_sclk) begin
        if (!sawRise) begin
          firstRise = csCnt;
          sawRise   = 1'b1;
        end
        monShift = {monShift[6:0], spi_mosi};
        monBits++;
        if (monBits == 8) begin
          monBits = 0;
          checkOutput("mosi_byte_expected", 32'(expBytes.size() > 0), 1);
          if (expBytes.size() > 0) checkOutput("mosi_byte", monShift, expBytes.pop_front());
        end
      end
      csCnt++;
    end else if (csCnt > 0) begin
      checkOutput("txn_expected", 32'(expTxn.size() > 0), 1);
      if (expTxn.size() > 0) begin
        monTxn = expTxn.pop_front();
        checkOutput("cs_low_cycles", csCnt, monTxn.csLen);
        checkOutput("first_sclk_rise", firstRise, monTxn.firstRise);
      end
      checkOutput("sclk_low_at_cs_rise", spi_sclk, 0);
      csCnt   = 0;
      monBits = 0;
      sawRise = 1'b0;
    end
    monPrev = spi_sclk;
  end

  // Response monitor: every resp_valid cycle consumes one scoreboard entry
  respExp_t monResp;
  always @(negedge sd_clock_i) begin
    if (!sd_reset_i && resp_valid) begin
      checkOutput("resp_expected", 32'(expResp.size() > 0), 1);
      if (expResp.size() > 0) begin
        monResp = expResp.pop_front();
        checkOutput("resp_r1", resp_r1, monResp.r1);
        checkOutput("resp_timeout", resp_timeout, monResp.timeout);
      end
    end
  end

  // Issue one command, push its expected bytes/response, then wait for completion
  task automatic applyStimulus(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] div,
                               input logic [7:0] crcByte, input int respAt, input logic [7:0] respVal,
                               input int pulseAt, input int abortAt);
    int         nPoll;
    logic [7:0] expR1;
    logic       expTo;
    bit         got;
    got   = 1'b0;
    nPoll = (respAt > 0) ? respAt : 8;
    expR1 = (respAt > 0) ? respVal : 8'hFF;
    expTo = (respAt == 0);
    cardRespAt  = respAt;
    cardRespVal = respVal;
    expBytes.push_back({2'b01, idx});
    expBytes.push_back(arg[31:24]);
    expBytes.push_back(arg[23:16]);
    expBytes.push_back(arg[15:8]);
    expBytes.push_back(arg[7:0]);
    expBytes.push_back(crcByte);
    for (int i = 0; i <= nPoll; i++) expBytes.push_back(8'hFF);
    if (abortAt == 0) begin
      expResp.push_back('{r1: expR1, timeout: expTo});
      expTxn.push_back('{csLen: (7 + nPoll) * 16 * (int'(div) + 1), firstRise: int'(div) + 1});
    end
    for (int c = 0; c < 100 && !cmd_ready; c++) @(negedge sd_clock_i);
    checkOutput("ready_before_accept", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_index = idx;
    cmd_arg   = arg;
    clk_div   = div;
    @(negedge sd_clock_i);
    cmd_valid = 1'b0;
    cmd_index = ~idx;
    cmd_arg   = ~arg;
    clk_div   = 8'd0;
    checkOutput("ready_low_after_accept", cmd_ready, 0);
    checkOutput("busy_after_accept", busy, 1);
    checkOutput("cs_low_after_accept", spi_cs_n, 0);
    checkOutput("timeout_cleared_on_accept", resp_timeout, 0);
    checkOutput("r1_held_after_accept", resp_r1, lastR1);
    for (int c = 0; c < 20000; c++) begin
      @(negedge sd_clock_i);
      if (pulseAt > 0 && c == pulseAt) begin
        checkOutput("busy_during_poll", busy, 1);
        checkOutput("ready_low_during_poll", cmd_ready, 0);
        cmd_valid = 1'b1;
        cmd_index = 6'd8;
        cmd_arg   = 32'h0000_01AA;
      end
      if (pulseAt > 0 && c == pulseAt + 1) cmd_valid = 1'b0;
      if (abortAt > 0 && c == abortAt) begin
        #2 sd_reset_i = 1'b1;
        #1;
        checkOutput("abort_cs_n", spi_cs_n, 1);
        checkOutput("abort_sclk", spi_sclk, 0);
        checkOutput("abort_mosi", spi_mosi, 1);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_resp_valid", resp_valid, 0);
        got = 1'b1;
        break;
      end
      if (resp_valid) begin
        got = 1'b1;
        break;
      end
    end
    cmd_valid = 1'b0;
    checkOutput("txn_finished_in_budget", 32'(got), 1);
    if (abortAt > 0) begin
      repeat (2) @(negedge sd_clock_i);
      expBytes.delete();
      expResp.delete();
      expTxn.delete();
      sd_reset_i = 1'b0;
      lastR1 = 8'hFF;
      lastTo = 1'b0;
      @(negedge sd_clock_i);
      checkOutput("post_abort_ready", cmd_ready, 1);
      checkOutput("post_abort_r1", resp_r1, 8'hFF);
    end else begin
      @(negedge sd_clock_i);
      checkOutput("resp_single_pulse", resp_valid, 0);
      checkOutput("ready_after_done", cmd_ready, 1);
      checkOutput("busy_after_done", busy, 0);
      checkOutput("cs_high_after_done", spi_cs_n, 1);
      checkOutput("r1_held", resp_r1, expR1);
      checkOutput("timeout_held", resp_timeout, expTo);
      lastR1 = expR1;
      lastTo = expTo;
      repeat (3) @(negedge sd_clock_i);
    end
  endtask

  // Directed sequence: reset values, normal commands, timeout, ignored request, abort
  initial begin
    repeat (3) @(negedge sd_clock_i);
    checkOutput("rst_cs_n", spi_cs_n, 1);
    checkOutput("rst_sclk", spi_sclk, 0);
    checkOutput("rst_mosi", spi_mosi, 1);
    checkOutput("rst_ready", cmd_ready, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_resp_valid", resp_valid, 0);
    checkOutput("rst_r1", resp_r1, 8'hFF);
    checkOutput("rst_timeout", resp_timeout, 0);
    sd_reset_i = 1'b0;
    repeat (2) @(negedge sd_clock_i);

    $display("[TB] CMD0, div 0, R1 on poll byte 2");
    applyStimulus(6'd0, 32'h0000_0000, 8'd0, 8'h95, 2, 8'h01, 0, 0);
    $display("[TB] CMD8, div 3, R1 on poll byte 1");
    applyStimulus(6'd8, 32'h0000_01AA, 8'd3, 8'h87, 1, 8'h01, 0, 0);
    $display("[TB] ACMD41 with MISO stuck high");
    applyStimulus(6'd41, 32'h4000_0000, 8'd0, 8'h77, 0, 8'hFF, 0, 0);
    $display("[TB] CMD0, div 1, stray cmd_valid during POLL");
    applyStimulus(6'd0, 32'h0000_0000, 8'd1, 8'h95, 1, 8'h00, 200, 0);
    $display("[TB] CMD8 aborted by reset in byte 3");
    applyStimulus(6'd8, 32'h0000_01AA, 8'd0, 8'h87, 1, 8'h01, 0, 52);
    $display("[TB] CMD0 after abort");
    applyStimulus(6'd0, 32'h0000_0000, 8'd0, 8'h95, 1, 8'h01, 0, 0);
    $display("[TB] CMD55, div 1, R1 0x05 on first poll byte");
    applyStimulus(6'd55, 32'h0000_0000, 8'd1, 8'h65, 1, 8'h05, 0, 0);

    repeat (10) @(negedge sd_clock_i);
    checkOutput("mosi_queue_drained", expBytes.size(), 0);
    checkOutput("resp_queue_drained", expResp.size(), 0);
    checkOutput("txn_queue_drained", expTxn.size(), 0);
    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule
